// File: rtl/gost_28147_89_pkg.sv
// Shared constants, types and arithmetic for the GOST 28147-89 gamming controller.
package gost_28147_89_pkg;

   localparam logic [31:0] C1 = 32'h01010104;
   localparam logic [31:0] C2 = 32'h01010101;

   typedef logic [63:0] block_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SYNC  = 3'd1,
      ST_READY = 3'd2,
      ST_GEN   = 3'd3,
      ST_OUT   = 3'd4
   } gamma_state_e;

   // End-around carry add: 0xFFFFFFFF stays a legal result, no normalization.
   function automatic logic [31:0] add_mod_2p32m1(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[31:0] + {31'd0, sum[32]};
   endfunction

endpackage

// File: rtl/gost_28147_89_gamma_ctrl_if.sv
// Block stream between source/sink (master) and the gamming controller (slave).
interface gost_28147_89_gamma_ctrl_if;
   import gost_28147_89_pkg::*;

   logic   in_valid;
   logic   in_ready;
   block_t in_data;
   logic   out_valid;
   logic   out_ready;
   block_t out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/gost_gamma_counter.sv
// N3/N4 synchro counter: seeded from E(S), stepped once per accepted block.
module gost_gamma_counter
   import gost_28147_89_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   seed,
   input  block_t seed_val,
   input  logic   step,
   output block_t n_next
);

   logic [31:0] n3;
   logic [31:0] n4;

   // Stepped value is offered combinationally so the core can be loaded with {N4',N3'}.
   assign n_next = {add_mod_2p32m1(n4, C1), n3 + C2};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n3 <= '0;
         n4 <= '0;
      end else if (seed) begin
         {n4, n3} <= seed_val;
      end else if (step) begin
         {n4, n3} <= n_next;
      end
   end

endmodule

// File: rtl/gost_28147_89_gamma_ctrl.sv
// GOST 28147-89 gamming sequencer around one ECB core; optional CFB mode
// is built when GOST_GAMMA_CFB_EN is defined.
//
// state | meaning
// IDLE  | no synchro loaded, waiting for iv_load
// SYNC  | encrypting S to seed N3/N4
// READY | accepting an input block
// GEN   | core encrypting the counter (or feedback block)
// OUT   | holding result until the sink takes it
module gost_28147_89_gamma_ctrl
   import gost_28147_89_pkg::*;
#(
   parameter int DONE_GUARD = 1
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   iv_load,
   input  block_t iv,
`ifdef GOST_GAMMA_CFB_EN
   input  logic   cfb_sel,
   input  logic   dir,
`endif
   gost_28147_89_gamma_ctrl_if.slave strm,
   output logic   busy,
   output logic   core_load,
   output logic   core_mode,
   output block_t core_pdata,
   input  block_t core_cdata,
   input  logic   core_done
);

   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_SYNC  = ST_SYNC;
   localparam logic [2:0] S_READY = ST_READY;
   localparam logic [2:0] S_GEN   = ST_GEN;
   localparam logic [2:0] S_OUT   = ST_OUT;
   localparam int GW = $clog2(DONE_GUARD + 2);

   logic [2:0]    state;
   logic          pend;
   logic          req;
   logic          stale;
   logic          first;
   logic [GW-1:0] guard;
   block_t        lat;
   block_t        fb;
   block_t        cnt_next;
   block_t        gen_out;
   block_t        byp_out;
   logic          cfb_on;
   logic          dir_on;
   logic          hs;
   logic          bypass;
   logic          done_ok;
   logic          done_acc;
   logic          load_evt;
   logic          seed;
   logic          pend_n;
   logic          req_n;
   logic          stale_n;
   logic          load_n;

`ifdef GOST_GAMMA_CFB_EN
   logic cfb_r;
   logic dir_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfb_r <= 1'b0;
         dir_r <= 1'b0;
      end else if (iv_load) begin
         cfb_r <= cfb_sel;
         dir_r <= dir;
      end
   end

   assign cfb_on = cfb_r;
   assign dir_on = dir_r;
`else
   assign cfb_on = 1'b0;
   assign dir_on = 1'b0;
`endif

   assign strm.in_ready = (state == S_READY) && !iv_load;
   assign hs            = strm.in_valid && strm.in_ready;
   assign bypass        = cfb_on && first;
   assign done_ok       = core_done && pend && !core_load && (guard == '0);
   assign done_acc      = done_ok && !stale;
   assign load_evt      = iv_load || (hs && !bypass);
   assign seed          = (state == S_SYNC) && done_acc && !iv_load;
   assign gen_out       = lat ^ core_cdata;
   assign byp_out       = strm.in_data ^ fb;
   assign busy          = (state != S_READY);
   assign core_mode     = 1'b0;

   gost_gamma_counter u_counter (
      .clk      (clk),
      .rst      (rst),
      .seed     (seed),
      .seed_val (core_cdata),
      .step     (hs && !cfb_on),
      .n_next   (cnt_next)
   );

   // A load requested while the core still owns an aborted run is deferred
   // until that run's done arrives; that done is then discarded as stale.
   always_comb begin
      pend_n  = pend;
      req_n   = req;
      stale_n = stale;
      load_n  = 1'b0;
      if (done_ok) begin
         pend_n  = 1'b0;
         stale_n = 1'b0;
      end
      if (iv_load && pend_n) stale_n = 1'b1;
      if (load_evt) req_n = 1'b1;
      if (req_n && !pend_n) begin
         load_n = 1'b1;
         req_n  = 1'b0;
         pend_n = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend      <= 1'b0;
         req       <= 1'b0;
         stale     <= 1'b0;
         core_load <= 1'b0;
         guard     <= '0;
      end else begin
         pend      <= pend_n;
         req       <= req_n;
         stale     <= stale_n;
         core_load <= load_n;
         if (load_n) guard <= GW'(DONE_GUARD);
         else if (!core_load && (guard != '0)) guard <= guard - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         core_pdata     <= '0;
         lat            <= '0;
         fb             <= '0;
         first          <= 1'b0;
         strm.out_data  <= '0;
         strm.out_valid <= 1'b0;
      end else if (iv_load) begin
         state          <= S_SYNC;
         core_pdata     <= iv;
         strm.out_valid <= 1'b0;
      end else begin
         case (state)
            S_SYNC: begin
               if (done_acc) begin
                  fb    <= core_cdata;
                  first <= 1'b1;
                  state <= S_READY;
               end
            end
            S_READY: begin
               if (hs) begin
                  lat   <= strm.in_data;
                  first <= 1'b0;
                  if (bypass) begin
                     strm.out_data  <= byp_out;
                     strm.out_valid <= 1'b1;
                     fb             <= dir_on ? strm.in_data : byp_out;
                     state          <= S_OUT;
                  end else begin
                     core_pdata <= cfb_on ? fb : cnt_next;
                     state      <= S_GEN;
                  end
               end
            end
            S_GEN: begin
               if (done_acc) begin
                  strm.out_data  <= gen_out;
                  strm.out_valid <= 1'b1;
                  fb             <= dir_on ? lat : gen_out;
                  state          <= S_OUT;
               end
            end
            S_OUT: begin
               if (strm.out_ready) begin
                  strm.out_valid <= 1'b0;
                  state          <= S_READY;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gost_28147_89_gamma_ctrl.sv
// Scoreboard bench for gost_28147_89_gamma_ctrl with an XOR core stub.
module tb_gost_28147_89_gamma_ctrl;
   import gost_28147_89_pkg::*;

   localparam logic [63:0] XMASK = 64'hA5A5A5A5_A5A5A5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iv_load = 1'b0;
   logic [63:0] iv = '0;
   logic        busy;
   logic        core_load;
   logic        core_mode;
   logic [63:0] core_pdata;
   logic [63:0] core_cdata;
   logic        core_done;
`ifdef GOST_GAMMA_CFB_EN
   logic        cfb_sel = 1'b0;
   logic        dir = 1'b0;
`endif

   gost_28147_89_gamma_ctrl_if sif ();

   gost_28147_89_gamma_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .iv_load    (iv_load),
      .iv         (iv),
`ifdef GOST_GAMMA_CFB_EN
      .cfb_sel    (cfb_sel),
      .dir        (dir),
`endif
      .strm       (sif),
      .busy       (busy),
      .core_load  (core_load),
      .core_mode  (core_mode),
      .core_pdata (core_pdata),
      .core_cdata (core_cdata),
      .core_done  (core_done)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          passed = 0;
   logic [63:0] exp_q[$];
   int          out_hs = 0;
   int          sink_mode = 0;
   int          proto_viol = 0;
   logic        prev_load = 1'b0;
   logic [63:0] mdl = '0;

   // Core stub: cdata = pdata ^ A5.., done (level) 3 cycles after load.
   logic [1:0]  st_cnt;
   logic [63:0] st_buf;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         core_done  <= 1'b0;
         core_cdata <= '0;
         st_cnt     <= '0;
         st_buf     <= '0;
      end else if (core_load) begin
         core_done <= 1'b0;
         st_cnt    <= 2'd3;
         st_buf    <= core_pdata;
      end else if (st_cnt != 2'd0) begin
         st_cnt <= st_cnt - 2'd1;
         if (st_cnt == 2'd1) begin
            core_done  <= 1'b1;
            core_cdata <= st_buf ^ XMASK;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   always @(negedge clk) begin
      case (sink_mode)
         0:       sif.out_ready = 1'b1;
         1:       sif.out_ready = 1'($urandom_range(0, 1));
         default: sif.out_ready = 1'b0;
      endcase
   end

   always begin
      @(negedge clk);
      #2;
      if (!rst && sif.out_valid && sif.out_ready) begin
         out_hs++;
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_out actual=%h required=no_output", sif.out_data);
         end else begin
            chk("out_data", sif.out_data, exp_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (core_load && prev_load) proto_viol++;
         if (core_load && st_cnt != 2'd0) proto_viol++;
      end
      prev_load = core_load;
   end

   // Reference: N4 += C1 with end-around carry, N3 += C2, gamma = E({N4,N3}).
   task automatic model_step(input logic [63:0] d, output logic [63:0] e);
      logic [63:0] s4;
      logic [31:0] n3;
      s4 = {32'd0, mdl[63:32]} + 64'h0000_0000_0101_0104;
      if (s4 > 64'h0000_0000_FFFF_FFFF) s4 = s4 - 64'h0000_0000_FFFF_FFFF;
      n3 = mdl[31:0] + 32'h01010101;
      mdl = {s4[31:0], n3};
      e = d ^ (mdl ^ XMASK);
   endtask

   task automatic do_iv(input logic [63:0] v);
      iv = v;
      iv_load = 1'b1;
      @(negedge clk);
      iv_load = 1'b0;
      mdl = v ^ XMASK;
   endtask

   task automatic send(input logic [63:0] d, input logic [63:0] e, input bit push);
      int n = 0;
      sif.in_valid = 1'b1;
      sif.in_data = d;
      while (!sif.in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sif.in_ready) begin
         if (push) exp_q.push_back(e);
         @(negedge clk);
      end else begin
         checks++;
         $display("FAIL send_timeout actual=in_ready_low required=handshake");
      end
      sif.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || sif.out_valid) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         checks++;
         $display("FAIL idle_timeout actual=pending_%0d required=0", exp_q.size());
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [63:0] od;
      logic [63:0] d;
      logic [63:0] e;
      int hs0;
      int n;
      sif.in_valid = 1'b0;
      sif.in_data = '0;
      sif.out_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 1);
      chk("rst_in_ready", sif.in_ready, 0);
      chk("rst_out_valid", sif.out_valid, 0);
      chk("rst_core_load", core_load, 0);
      chk("rst_core_pdata", core_pdata, 0);
      chk("rst_out_data", sif.out_data, 0);
      chk("core_mode", core_mode, 0);
      rst = 1'b0;
      @(negedge clk);

      // Known vectors: iv=0, two zero blocks.
      do_iv(64'h0);
      send(64'h0, 64'h0303030C_03030303, 1);
      send(64'h0, 64'h02020208_02020202, 1);
      wait_idle();

      // N4 end-around carry.
      do_iv(64'h5B5B5B59_5A5A5A5A);
      send(64'h0, 64'hA5A5A5A4_A4A4A4A5, 1);
      wait_idle();

      // Backpressure hold.
      do_iv({$urandom, $urandom});
      sink_mode = 2;
      @(negedge clk);
      d = {$urandom, $urandom};
      model_step(d, e);
      send(d, e, 1);
      n = 0;
      while (!sif.out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_out_valid", sif.out_valid, 1);
      od = sif.out_data;
      hs0 = out_hs;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_out_data", sif.out_data, od);
         chk("bp_flags", {sif.in_ready, core_load, sif.out_valid, busy}, 4'b0011);
      end
      sink_mode = 0;
      repeat (5) @(negedge clk);
      chk("bp_one_handshake", 64'(out_hs - hs0), 1);
      chk("bp_ready_state", {sif.out_valid, busy, sif.in_ready}, 3'b001);

      // iv_load while GEN: the aborted block must produce nothing.
      send({$urandom, $urandom}, 64'h0, 0);
      chk("abort_in_gen", {busy, core_load}, 2'b11);
      do_iv(64'h0);
      send(64'h0, 64'h0303030C_03030303, 1);
      wait_idle();

      // Async reset mid-GEN.
      send({$urandom, $urandom}, 64'h0, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", busy, 1);
      chk("arst_in_ready", sif.in_ready, 0);
      chk("arst_out_valid", sif.out_valid, 0);
      chk("arst_core_load", core_load, 0);
      chk("arst_core_pdata", core_pdata, 0);
      chk("arst_out_data", sif.out_data, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_in_ready", sif.in_ready, 0);
      end

`ifdef GOST_GAMMA_CFB_EN
      cfb_sel = 1'b1;
      dir = 1'b0;
      do_iv(64'h0);
      send(64'h0, 64'hA5A5A5A5_A5A5A5A5, 1);
      send(64'h0, 64'h0, 1);
      wait_idle();
      cfb_sel = 1'b0;
`endif

      // Randomized counter-mode traffic with random sink stalls.
      for (int r = 0; r < 3; r++) begin
         sink_mode = 1;
         do_iv({$urandom, $urandom});
         for (int b = 0; b < 8; b++) begin
            d = {$urandom, $urandom};
            model_step(d, e);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(d, e, 1);
         end
         wait_idle();
      end
      sink_mode = 0;
      repeat (3) @(negedge clk);

      chk("core_load_protocol", 64'(proto_viol), 0);
      chk("queue_drained", 64'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
